uart_boot_loader: RTL and testbench

//   Upstream of the pipelined core. Receives a program image over UART and writes it word-by-word

---
 rtl/uart_boot_pkg.sv | 7 +
 rtl/uart_rx.sv | 59 +++++
 rtl/uart_tx.sv | 39 +++
 rtl/uart_boot_loader.sv | 115 +++++++++++
 tb/tb_uart_boot_loader.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/uart_boot_pkg.sv
// uart_boot_pkg: shared state encoding and protocol byte values for the UART boot loader
package uart_boot_pkg;
    typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR} state_t;
    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] ACK_BYTE  = 8'h06;
    localparam logic [7:0] NAK_BYTE  = 8'h15;
endpackage

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver with 2-flop synchronizer, start-bit recheck and framing-error flag
module uart_rx #(
    parameter int CPB = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_ferr
);
    localparam int CW = (CPB > 2) ? $clog2(CPB) : 1;
    localparam logic [CW-1:0] HALF = CW'(CPB / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(CPB - 1);
    logic [2:0]    sync;
    logic [1:0]    ph;
    logic [CW-1:0] cnt;
    logic [2:0]    bitn;
    logic          s;
    assign s = sync[1];
    // phase 0 idle, 1 start recheck, 2 data bits, 3 stop bit; sync[2] only feeds edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync     <= 3'b111;
            ph       <= 2'd0;
            cnt      <= '0;
            bitn     <= 3'd0;
            rx_data  <= 8'd0;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            sync     <= {sync[1:0], rx};
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
            case (ph)
                2'd0: if (sync[2] && !s) begin
                    ph  <= 2'd1;
                    cnt <= '0;
                end
                2'd1: if (cnt == HALF) begin
                    ph   <= s ? 2'd0 : 2'd2;
                    cnt  <= '0;
                    bitn <= 3'd0;
                end else cnt <= cnt + CW'(1);
                2'd2: if (cnt == FULL) begin
                    cnt     <= '0;
                    rx_data <= {s, rx_data[7:1]};
                    bitn    <= bitn + 3'd1;
                    if (bitn == 3'd7) ph <= 2'd3;
                end else cnt <= cnt + CW'(1);
                default: if (cnt == FULL) begin
                    ph       <= 2'd0;
                    rx_valid <= s;
                    rx_ferr  <= !s;
                end else cnt <= cnt + CW'(1);
            endcase
        end
    end
endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1 transmitter; a start request is ignored while a byte is in flight
module uart_tx #(
    parameter int CPB = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx
);
    localparam int CW = (CPB > 2) ? $clog2(CPB) : 1;
    localparam logic [CW-1:0] FULL = CW'(CPB - 1);
    logic [9:0]    sh;
    logic [CW-1:0] cnt;
    logic [3:0]    n;
    logic          act;
    assign tx = act ? sh[0] : 1'b1;
    // shift out {stop, data, start} LSB first, one bit per CPB clocks
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh  <= 10'h3FF;
            cnt <= '0;
            n   <= 4'd0;
            act <= 1'b0;
        end else if (!act) begin
            if (start) begin
                sh  <= {1'b1, data, 1'b0};
                cnt <= '0;
                n   <= 4'd0;
                act <= 1'b1;
            end
        end else if (cnt == FULL) begin
            cnt <= '0;
            sh  <= {1'b1, sh[9:1]};
            n   <= n + 4'd1;
            if (n == 4'd9) act <= 1'b0;
        end else cnt <= cnt + CW'(1);
    end
endmodule

// File: rtl/uart_boot_loader.sv
// uart_boot_loader: loads a UART program image into RAM and releases the core on a good checksum (ACK/NAK reply under UART_BOOT_LOADER_ACK_EN)
module uart_boot_loader
    import uart_boot_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 115_200,
    parameter int ADDR_W   = 13
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx,
    output logic              tx,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_din,
    output logic              core_rst_n,
    output logic              busy,
    output logic              error
);
    localparam int CPB = CLK_FREQ / BAUD;
    state_t      state;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ferr;
    logic [7:0]  len_lo;
    logic [15:0] left;
    logic [15:0] n_len;
    logic [1:0]  k;
    logic [7:0]  csum;

    uart_rx #(.CPB(CPB)) u_rx (
        .clk     (clk),
        .rst_n   (rst_n),
        .rx      (rx),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .rx_ferr (rx_ferr)
    );

    assign n_len      = {rx_data, len_lo};
    assign core_rst_n = state == DONE;
    assign error      = state == ERR;
    assign busy       = state inside {LEN_LO, LEN_HI, DATA, CSUM};

    // frame parser; a completed word is written the cycle after its last byte, then the address advances
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            mem_we   <= 4'h0;
            mem_addr <= '0;
            mem_din  <= 32'd0;
            len_lo   <= 8'd0;
            left     <= 16'd0;
            k        <= 2'd0;
            csum     <= 8'd0;
        end else begin
            if (mem_we != 4'h0) begin
                mem_we   <= 4'h0;
                mem_addr <= mem_addr + ADDR_W'(1);
            end
            if (rx_ferr && state != DONE) state <= ERR;
            else if (rx_valid) begin
                case (state)
                    IDLE, ERR: if (rx_data == SYNC_BYTE) begin
                        state    <= LEN_LO;
                        mem_addr <= '0;
                        csum     <= 8'd0;
                        k        <= 2'd0;
                    end
                    LEN_LO: begin
                        len_lo <= rx_data;
                        state  <= LEN_HI;
                    end
                    LEN_HI: begin
                        left  <= n_len;
                        state <= n_len == 16'd0 ? CSUM :
                                 {1'b0, n_len} > 17'(2 ** ADDR_W) ? ERR : DATA;
                    end
                    DATA: begin
                        mem_din[{k, 3'b000} +: 8] <= rx_data;
                        csum <= csum ^ rx_data;
                        k    <= k + 2'd1;
                        if (k == 2'd3) begin
                            mem_we <= 4'hF;
                            left   <= left - 16'd1;
                            if (left == 16'd1) state <= CSUM;
                        end
                    end
                    CSUM: state <= rx_data == csum ? DONE : ERR;
                    default: ;
                endcase
            end
        end
    end

`ifdef UART_BOOT_LOADER_ACK_EN
    state_t prev;
    logic   go;
    assign go = (state == DONE && prev != DONE) || (state == ERR && prev != ERR);
    // remember last state so the reply fires once on entry to DONE or ERR
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev <= IDLE;
        else prev <= state;
    end
    uart_tx #(.CPB(CPB)) u_tx (
        .clk  (clk),
        .rst_n(rst_n),
        .start(go),
        .data (state == DONE ? ACK_BYTE : NAK_BYTE),
        .tx   (tx)
    );
`else
    assign tx = 1'b1;
`endif
endmodule

// File: tb/tb_uart_boot_loader.sv
// tb_uart_boot_loader: table-driven frame tests with write and reply scoreboards
module tb_uart_boot_loader;
    localparam int CPB = 8;
    logic        clk = 0;
    logic        rst_n = 0;
    logic        rx = 1;
    logic        tx;
    logic [3:0]  mem_we;
    logic [12:0] mem_addr;
    logic [31:0] mem_din;
    logic        core_rst_n, busy, error;
    int checks = 0;
    int fails = 0;

    typedef struct { logic [12:0] a; logic [31:0] d; } wr_t;
    typedef struct {
        bit          rst;
        logic [15:0] n;
        logic [31:0] w0, w1;
        bit          bad;
        bit          exp_core, exp_err;
    } vec_t;
    wr_t        wq[$];
    logic [7:0] tq[$];
    vec_t       vt[6];

    uart_boot_loader #(.CLK_FREQ(8), .BAUD(1), .ADDR_W(13)) dut (
        .clk(clk), .rst_n(rst_n), .rx(rx), .tx(tx), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_din(mem_din), .core_rst_n(core_rst_n), .busy(busy), .error(error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
        rx = 1'b0; tick(CPB);
        for (int i = 0; i < 8; i++) begin rx = b[i]; tick(CPB); end
        rx = stop; tick(CPB);
        rx = 1'b1; tick(2);
    endtask

    task automatic expect_reply(input logic [7:0] b);
`ifdef UART_BOOT_LOADER_ACK_EN
        tq.push_back(b);
`endif
    endtask

    task automatic do_reset();
        rst_n = 1'b0; tick(2); rst_n = 1'b1; tick(2);
    endtask

    task automatic send_frame(input logic [15:0] n, input logic [31:0] w0, input logic [31:0] w1, input bit bad);
        logic [31:0] w[2];
        logic [7:0]  cs;
        w[0] = w0; w[1] = w1; cs = 8'd0;
        send_byte(8'hA5); send_byte(n[7:0]); send_byte(n[15:8]);
        if (n > 16'd2) return;
        for (int i = 0; i < int'(n); i++) begin
            wq.push_back('{a: 13'(i), d: w[i]});
            for (int j = 0; j < 4; j++) begin
                send_byte(w[i][8*j +: 8]);
                cs ^= w[i][8*j +: 8];
            end
        end
        send_byte(bad ? 8'h00 : cs);
    endtask

    // write scoreboard: every write must be expected, a full-word enable, and last one cycle
    logic [3:0] prev_we = 4'h0;
    always @(negedge clk) begin
        if (mem_we !== 4'h0) begin
            chk("we_value", {28'd0, mem_we}, 32'hF);
            if (prev_we !== 4'h0) chk("we_one_cycle", {28'd0, prev_we}, 32'h0);
            if (wq.size() == 0) chk("unexpected_write", {19'd0, mem_addr}, 32'hFFFFFFFF);
            else begin
                wr_t e;
                e = wq.pop_front();
                chk("wr_addr", {19'd0, mem_addr}, {19'd0, e.a});
                chk("wr_data", mem_din, e.d);
            end
        end
        prev_we <= mem_we;
    end

    // reply scoreboard: decode any byte on tx and compare with the queued response
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (tx === 1'b0) begin
                repeat (CPB / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = tx;
                end
                repeat (CPB) @(negedge clk);
                chk("tx_stop", {31'd0, tx}, 32'd1);
                if (tq.size() == 0) chk("unexpected_tx", {24'd0, b}, 32'hFFFFFFFF);
                else chk("tx_byte", {24'd0, b}, {24'd0, tq.pop_front()});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vt[0] = '{rst: 1, n: 16'd2, w0: 32'h12345678, w1: 32'hDEADBEEF, bad: 0, exp_core: 1, exp_err: 0};
        vt[1] = '{rst: 1, n: 16'd2, w0: 32'h12345678, w1: 32'hDEADBEEF, bad: 1, exp_core: 0, exp_err: 1};
        vt[2] = '{rst: 0, n: 16'd2, w0: 32'h12345678, w1: 32'hDEADBEEF, bad: 0, exp_core: 1, exp_err: 0};
        vt[3] = '{rst: 1, n: 16'd0, w0: 32'h0, w1: 32'h0, bad: 0, exp_core: 1, exp_err: 0};
        vt[4] = '{rst: 1, n: 16'd1, w0: 32'hCAFEF00D, w1: 32'h0, bad: 0, exp_core: 1, exp_err: 0};
        vt[5] = '{rst: 1, n: 16'h2001, w0: 32'h0, w1: 32'h0, bad: 0, exp_core: 0, exp_err: 1};
        tick(3);
        chk("rst_we", {28'd0, mem_we}, 32'h0);
        chk("rst_addr", {19'd0, mem_addr}, 32'h0);
        chk("rst_din", mem_din, 32'h0);
        chk("rst_core", {31'd0, core_rst_n}, 32'h0);
        chk("rst_busy", {31'd0, busy}, 32'h0);
        chk("rst_err", {31'd0, error}, 32'h0);
        chk("rst_tx", {31'd0, tx}, 32'h1);
        rst_n = 1'b1; tick(2);

        foreach (vt[i]) begin
            if (vt[i].rst) do_reset();
            send_frame(vt[i].n, vt[i].w0, vt[i].w1, vt[i].bad);
            tick(4);
            chk($sformatf("v%0d_core", i), {31'd0, core_rst_n}, {31'd0, vt[i].exp_core});
            chk($sformatf("v%0d_err", i), {31'd0, error}, {31'd0, vt[i].exp_err});
            chk($sformatf("v%0d_busy", i), {31'd0, busy}, 32'h0);
            if (vt[i].exp_core) expect_reply(8'h06);
            if (vt[i].exp_err) expect_reply(8'h15);
            tick(200);
        end

        // framing error in the middle of a word
        do_reset();
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00); send_byte(8'h78);
        chk("ferr_busy_before", {31'd0, busy}, 32'h1);
        send_byte(8'h56, 1'b0);
        tick(4);
        chk("ferr_err", {31'd0, error}, 32'h1);
        chk("ferr_core", {31'd0, core_rst_n}, 32'h0);
        expect_reply(8'h15);
        tick(200);

        // short low glitch on an idle line yields no byte
        do_reset();
        rx = 1'b0; tick(2); rx = 1'b1; tick(40);
        chk("glitch_busy", {31'd0, busy}, 32'h0);
        chk("glitch_err", {31'd0, error}, 32'h0);
        send_frame(16'd0, 32'h0, 32'h0, 0);
        tick(4);
        chk("glitch_then_load", {31'd0, core_rst_n}, 32'h1);
        expect_reply(8'h06);
        tick(200);

        // reset mid-load, then a fresh load from address 0
        do_reset();
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        chk("mid_busy", {31'd0, busy}, 32'h1);
        rst_n = 1'b0; #1;
        chk("mid_rst_we", {28'd0, mem_we}, 32'h0);
        chk("mid_rst_addr", {19'd0, mem_addr}, 32'h0);
        chk("mid_rst_din", mem_din, 32'h0);
        chk("mid_rst_core", {31'd0, core_rst_n}, 32'h0);
        chk("mid_rst_busy", {31'd0, busy}, 32'h0);
        chk("mid_rst_err", {31'd0, error}, 32'h0);
        chk("mid_rst_tx", {31'd0, tx}, 32'h1);
        tick(2); rst_n = 1'b1; tick(2);
        send_frame(16'd2, 32'h0BADF00D, 32'h8765_4321, 0);
        tick(4);
        chk("reload_core", {31'd0, core_rst_n}, 32'h1);
        expect_reply(8'h06);
        tick(200);

        chk("writes_pending", wq.size(), 32'd0);
        chk("replies_pending", tq.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
